// File: rtl/divider_seq_param.sv
// Parametrised radix-2 sequential restoring divider, signed/unsigned.
// Optional macro DIVIDER_LZ_SKIP_EN skips leading-zero iterations.
module divider_seq_param #(
    parameter int W_DVD = 16,
    parameter int W_DVS = 8,
    parameter int W_CNT = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [W_DVD-1:0] dividend,
    input  logic [W_DVS-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [W_DVD-1:0] quotient,
    output logic [W_DVS-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_ZERO
    } state_t;

    state_t state, state_nx;

    logic [W_DVD-1:0] acc;
    logic [W_DVS-1:0] rem;
    logic [W_DVS:0]   dvs_mag;
    logic [W_CNT-1:0] cnt;
    logic             dvd_neg;
    logic             q_neg;
    logic             ovf_pend;

    logic             dvd_sgn;
    logic             dvs_sgn;
    logic [W_DVD:0]   dvd_ext;
    logic [W_DVD:0]   dvd_abs;
    logic [W_DVS:0]   dvs_ext;
    logic [W_DVS:0]   dvs_abs;
    logic [W_DVD-1:0] dvd_mag;
    logic [W_DVS:0]   partial;
    logic [W_DVS+1:0] trial;
    logic             q_bit;
    logic [W_DVS-1:0] rem_nx;
    logic [W_DVD-1:0] acc_init;
    logic [W_CNT-1:0] cnt_init;
    logic             unused_bits;

    // Operand magnitudes; one extra bit so MIN negates exactly.
    assign dvd_sgn = signed_mode & dividend[W_DVD-1];
    assign dvs_sgn = signed_mode & divisor[W_DVS-1];
    assign dvd_ext = {dvd_sgn, dividend};
    assign dvs_ext = {dvs_sgn, divisor};
    assign dvd_abs = dvd_sgn ? -dvd_ext : dvd_ext;
    assign dvs_abs = dvs_sgn ? -dvs_ext : dvs_ext;
    assign dvd_mag = dvd_abs[W_DVD-1:0];

    // One restoring step: bring down next dividend bit, trial subtract.
    assign partial = {rem, acc[W_DVD-1]};
    assign trial   = {1'b0, partial} - {1'b0, dvs_mag};
    assign q_bit   = ~trial[W_DVS+1];
    assign rem_nx  = q_bit ? trial[W_DVS-1:0] : partial[W_DVS-1:0];

    // Magnitude top bit is always zero after truncation; trial bit W_DVS
    // is zero whenever it is kept.
    assign unused_bits = ^{dvd_abs[W_DVD], trial[W_DVS]};

`ifdef DIVIDER_LZ_SKIP_EN
    logic [W_CNT-1:0] lz;

    // Leading zeros of the dividend magnitude, capped at W_DVD-1.
    always_comb begin
        lz = W_CNT'(W_DVD - 1);
        for (int i = 0; i < W_DVD; i++) begin
            if (dvd_mag[i]) lz = W_CNT'(W_DVD - 1 - i);
        end
    end

    assign acc_init = dvd_mag << lz;
    assign cnt_init = W_CNT'(W_DVD - 1) - lz;
`else
    assign acc_init = dvd_mag;
    assign cnt_init = W_CNT'(W_DVD - 1);
`endif

    assign busy = (state != S_IDLE);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state selection.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = (divisor == '0) ? S_ZERO : S_CALC;
            end
            S_CALC: begin
                if (cnt == '0) state_nx = S_FIX;
            end
            S_FIX:   state_nx = S_IDLE;
            S_ZERO:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix-up and results.
    always_ff @(posedge clock) begin
        if (reset) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            done        <= 1'b0;
            acc         <= '0;
            rem         <= '0;
            dvs_mag     <= '0;
            cnt         <= '0;
            dvd_neg     <= 1'b0;
            q_neg       <= 1'b0;
            ovf_pend    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        acc         <= acc_init;
                        rem         <= '0;
                        dvs_mag     <= dvs_abs;
                        cnt         <= cnt_init;
                        dvd_neg     <= dvd_sgn;
                        q_neg       <= dvd_sgn ^ dvs_sgn;
                        ovf_pend    <= signed_mode
                                    && dividend == {1'b1, {(W_DVD-1){1'b0}}}
                                    && divisor == '1;
                    end
                end
                S_CALC: begin
                    acc <= {acc[W_DVD-2:0], q_bit};
                    rem <= rem_nx;
                    cnt <= cnt - W_CNT'(1);
                end
                S_FIX: begin
                    quotient  <= q_neg ? -acc : acc;
                    remainder <= dvd_neg ? -rem : rem;
                    overflow  <= ovf_pend;
                    done      <= 1'b1;
                end
                S_ZERO: begin
                    quotient    <= '1;
                    remainder   <= '0;
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq_param.sv
// Scoreboard bench for divider_seq_param at 16/8 widths.
// Stimulus pushes expectations; a monitor checks each done pulse.
module tb_divider_seq_param;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_mode;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    divider_seq_param #(
        .W_DVD(16),
        .W_DVS(8),
        .W_CNT(5)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .signed_mode(signed_mode),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
        logic        o;
        int          cyc;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.nm, ".quot"}, 32'(quotient), 32'(e.q));
                chk({e.nm, ".rem"},  32'(remainder), 32'(e.r));
                chk({e.nm, ".dbz"},  32'(div_by_zero), 32'(e.z));
                chk({e.nm, ".ovf"},  32'(overflow), 32'(e.o));
                chk({e.nm, ".lat"},  32'(cyc), 32'(e.cyc));
                chk({e.nm, ".busy"}, 32'(busy), 32'd0);
            end
        end
    end

    // Drive one request at the current negedge; start drops a cycle later.
    task automatic issue(input logic sm, input logic [15:0] a,
                         input logic [7:0] b, input logic [15:0] eq,
                         input logic [7:0] er, input logic ez,
                         input logic eo, input int lat, input string nm,
                         input bit push_it);
        exp_t e;
        signed_mode = sm;
        dividend    = a;
        divisor     = b;
        start       = 1'b1;
        if (push_it) begin
            e.q   = eq;
            e.r   = er;
            e.z   = ez;
            e.o   = eo;
            e.cyc = cyc + 1 + lat;
            e.nm  = nm;
            sbq.push_back(e);
        end
        @(negedge clock);
        start = 1'b0;
        chk({nm, ".busy_rise"}, 32'(busy), 32'd1);
        chk({nm, ".flags_clr"}, 32'({div_by_zero, overflow}), 32'd0);
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            #1;
            if (sbq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: got %0d pending expected 0", nm, sbq.size());
            sbq.delete();
        end
        @(negedge clock);
    endtask

    task automatic run(input logic sm, input logic [15:0] a,
                       input logic [7:0] b, input logic [15:0] eq,
                       input logic [7:0] er, input logic ez,
                       input logic eo, input int lat, input string nm);
        issue(sm, a, b, eq, er, ez, eo, lat, nm, 1'b1);
        wait_idle(nm);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        dividend    = '0;
        divisor     = '0;
        repeat (3) @(negedge clock);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.outs", 32'({quotient, remainder, div_by_zero, overflow}), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        run(1'b0, 16'd1000, 8'd7,  16'd142,  8'd6,    1'b0, 1'b0, 17, "u1000_7");
        run(1'b1, 16'hFC18, 8'd7,  16'hFF72, 8'hFA,   1'b0, 1'b0, 17, "sn1000_7");
        run(1'b1, 16'd1000, 8'hF9, 16'hFF72, 8'h06,   1'b0, 1'b0, 17, "s1000_n7");
        run(1'b1, 16'hFC18, 8'hF9, 16'd142,  8'hFA,   1'b0, 1'b0, 17, "sn1000_n7");
        run(1'b0, 16'h1234, 8'h00, 16'hFFFF, 8'h00,   1'b1, 1'b0, 1,  "dbz");
        run(1'b0, 16'd9,    8'd3,  16'd3,    8'd0,    1'b0, 1'b0, 17, "u9_3");
        run(1'b1, 16'h8000, 8'hFF, 16'h8000, 8'h00,   1'b0, 1'b1, 17, "s_ovf");
        run(1'b0, 16'h8000, 8'hFF, 16'h0080, 8'h80,   1'b0, 1'b0, 17, "u8000_ff");
        run(1'b1, 16'hFFF9, 8'd2,  16'hFFFD, 8'hFF,   1'b0, 1'b0, 17, "sn7_2");
        run(1'b1, 16'd100,  8'h80, 16'd0,    8'd100,  1'b0, 1'b0, 17, "s100_min");

        // Starts while busy are dropped; only one done may appear.
        issue(1'b0, 16'd100, 8'd9, 16'd11, 8'd1, 1'b0, 1'b0, 17, "ign", 1'b1);
        repeat (4) @(negedge clock);
        dividend = 16'd50000;
        divisor  = 8'd3;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        divisor = 8'd0;
        start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_idle("ign");
        repeat (20) @(negedge clock);

        // Start in the done cycle is accepted straight away.
        issue(1'b0, 16'hFFFF, 8'hFF, 16'd257, 8'd0, 1'b0, 1'b0, 17, "b2b_a", 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) break;
        end
        issue(1'b1, 16'h7FFF, 8'h80, 16'hFF01, 8'h7F, 1'b0, 1'b0, 17, "b2b_b", 1'b1);
        wait_idle("b2b");

        // Reset mid-operation discards it without a done.
        issue(1'b0, 16'd5000, 8'd7, 16'd0, 8'd0, 1'b0, 1'b0, 17, "rst_op", 1'b0);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.outs", 32'({quotient, remainder, div_by_zero, overflow}), 32'd0);
        repeat (25) @(negedge clock);
        run(1'b0, 16'd255, 8'd16, 16'd15, 8'd15, 1'b0, 1'b0, 17, "u255_16");

        repeat (5) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
